// File: rtl/range_match_tree_ctrl.sv
// Iterative range classifier: binary-searches a sorted boundary table one tree
// level per cycle through a single shared compare element.

module range_match_tree_pe #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] in_i,
  input  logic [DATA_W-1:0] target_i,
  output logic              gtet_o
);

  assign gtet_o = (in_i >= target_i);

endmodule

module range_match_tree_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [DEPTH-1:0]  cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DEPTH:0]    out_range,
  output logic              busy
);

  localparam int NB    = (1 << DEPTH) - 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   key_q, key_d;
  logic [DEPTH:0]      pos_q, pos_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [DATA_W-1:0]   bound_q [NB];

  logic [DEPTH-1:0]    step;
  logic [DEPTH-1:0]    probe;
  logic [DATA_W-1:0]   target;
  logic                gtet;
  logic                accept;
  logic                cfg_wr;
  logic                last_lvl;

  assign accept   = (state_q == IDLE) && in_valid;
  assign cfg_wr   = cfg_we && (state_q == IDLE) && (cfg_addr != DEPTH'(NB));
  assign last_lvl = (level_q == '0);
  assign step     = DEPTH'(1) << level_q;
  assign probe    = pos_q[DEPTH-1:0] + step - DEPTH'(1);

  // Probe index NB is never reached while searching; guard it so idle reads stay defined.
  always_comb begin
    target = '0;
    if (probe != DEPTH'(NB)) begin
      target = bound_q[probe];
    end
  end

  range_match_tree_pe #(
    .DATA_W (DATA_W)
  ) u_pe (
    .in_i     (key_q),
    .target_i (target),
    .gtet_o   (gtet)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SEARCH;
      SEARCH:  if (last_lvl) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_range = pos_q;
  end

  // Search datapath: pos accumulates the lower bound of the interval still in play.
  always_comb begin
    key_d   = key_q;
    pos_d   = pos_q;
    level_d = level_q;
    if (accept) begin
      key_d   = in_key;
      pos_d   = '0;
      level_d = LVL_W'(DEPTH - 1);
    end else if (state_q == SEARCH) begin
      if (gtet) begin
        pos_d = pos_q + {1'b0, step};
      end
      if (!last_lvl) begin
        level_d = level_q - LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q   <= '0;
      pos_q   <= '0;
      level_q <= '0;
    end else begin
      key_q   <= key_d;
      pos_q   <= pos_d;
      level_q <= level_d;
    end
  end

  // Table writes land only while idle, so an in-flight search sees a frozen table.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NB; i++) begin
        bound_q[i] <= '0;
      end
    end else if (cfg_wr) begin
      bound_q[cfg_addr] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_range_match_tree_ctrl.sv
// Bench for range_match_tree_ctrl: directed scenarios plus random tables and keys
// scored against a count-of-boundaries reference model.

module tb_range_match_tree_ctrl;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 3;
  localparam int NB     = 7;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_we = 1'b0;
  logic [DEPTH-1:0]  cfg_addr = '0;
  logic [DATA_W-1:0] cfg_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_key = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DEPTH:0]    out_range;
  logic              busy;

  int vectors = 0;
  int miscompares = 0;
  int mdl_tbl [NB];

  always #5 clk = ~clk;

  range_match_tree_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_range (out_range),
    .busy      (busy)
  );

  // Range of a key in a sorted table = number of boundaries not above it.
  function automatic int ref_range(input int key);
    int n = 0;
    for (int i = 0; i < NB; i++) if (mdl_tbl[i] <= key) n++;
    return n;
  endfunction

  task automatic write_cfg(input int a, input int d);
    cfg_we = 1'b1; cfg_addr = a[2:0]; cfg_data = d[7:0];
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (a < NB) mdl_tbl[a] = d;
  endtask

  task automatic load_std_table();
    for (int i = 0; i < NB; i++) write_cfg(i, 10 * (i + 1));
  endtask

  // mode 0: plain query, 1: cfg write on the accept edge, 2: cfg write during SEARCH
  task automatic do_query(input int key, input int hold, input int mode, input int ca, input int cd,
                          output int res, output int lat, output bit ir_bad, output bit hold_bad,
                          output bit timeout);
    ir_bad = 0; hold_bad = 0; timeout = 0; res = -1; lat = 0;
    in_valid = 1'b1; in_key = key[7:0];
    if (mode == 1) begin cfg_we = 1'b1; cfg_addr = ca[2:0]; cfg_data = cd[7:0]; end
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    if (mode == 2) begin cfg_we = 1'b1; cfg_addr = ca[2:0]; cfg_data = cd[7:0]; end
    while (out_valid !== 1'b1 && lat < 20) begin
      if (in_ready !== 1'b0) ir_bad = 1;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      lat++;
    end
    cfg_we = 1'b0;
    if (out_valid !== 1'b1) begin timeout = 1; return; end
    res = int'(out_range);
    for (int h = 0; h < hold; h++) begin
      if (out_valid !== 1'b1 || out_range !== res[3:0] || in_ready !== 1'b0 || busy !== 1'b1) hold_bad = 1;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) hold_bad = 1;
  endtask

  task automatic test_reset();
    int res, lat; bit irb, hb, to;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_range !== 4'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got rdy=%b vld=%b rng=%0d busy=%b want 1 0 0 0", in_ready, out_valid, out_range, busy);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < NB; i++) mdl_tbl[i] = 0;
    do_query(int'($urandom_range(0, 255)), 0, 0, 0, 0, res, lat, irb, hb, to);
    vectors++;
    if (to || res !== 7) begin
      miscompares++;
      $display("FAIL reset_zero_table got %0d want 7", res);
    end
  endtask

  task automatic test_basic();
    int keys [6] = '{5, 10, 35, 69, 70, 255};
    int exps [6] = '{0, 1, 3, 6, 7, 7};
    int res, lat; bit irb, hb, to;
    load_std_table();
    for (int i = 0; i < 6; i++) begin
      do_query(keys[i], 0, 0, 0, 0, res, lat, irb, hb, to);
      vectors++;
      if (to || res !== exps[i]) begin
        miscompares++;
        $display("FAIL basic_range key=%0d got %0d want %0d", keys[i], res, exps[i]);
      end
      vectors++;
      if (lat !== 3 || irb) begin
        miscompares++;
        $display("FAIL basic_latency key=%0d got lat=%0d ready_during=%0d want lat=3 ready_during=0", keys[i], lat, irb);
      end
    end
  endtask

  task automatic test_backpressure();
    int res, lat; bit irb, hb, to;
    do_query(45, 5, 0, 0, 0, res, lat, irb, hb, to);
    vectors++;
    if (to || res !== 4 || hb || irb) begin
      miscompares++;
      $display("FAIL backpressure got range=%0d hold_bad=%0d want range=4 hold_bad=0", res, hb);
    end
    do_query(15, 0, 0, 0, 0, res, lat, irb, hb, to);
    vectors++;
    if (to || res !== 1) begin
      miscompares++;
      $display("FAIL backpressure_next got %0d want 1", res);
    end
  endtask

  task automatic test_cfg_during_search();
    int res, lat; bit irb, hb, to;
    do_query(25, 0, 2, 2, 100, res, lat, irb, hb, to);
    vectors++;
    if (to || res !== 2) begin
      miscompares++;
      $display("FAIL cfg_busy_query got %0d want 2", res);
    end
    do_query(25, 0, 0, 0, 0, res, lat, irb, hb, to);
    vectors++;
    if (to || res !== 2) begin
      miscompares++;
      $display("FAIL cfg_busy_dropped got %0d want 2", res);
    end
  endtask

  task automatic test_cfg_then_search();
    int res, lat; bit irb, hb, to;
    write_cfg(2, 22);
    do_query(23, 0, 0, 0, 0, res, lat, irb, hb, to);
    vectors++;
    if (to || res !== 3) begin
      miscompares++;
      $display("FAIL cfg_idle_k23 got %0d want 3", res);
    end
    do_query(21, 0, 0, 0, 0, res, lat, irb, hb, to);
    vectors++;
    if (to || res !== 2) begin
      miscompares++;
      $display("FAIL cfg_idle_k21 got %0d want 2", res);
    end
    mdl_tbl[2] = 24;
    do_query(23, 0, 1, 2, 24, res, lat, irb, hb, to);
    vectors++;
    if (to || res !== 2) begin
      miscompares++;
      $display("FAIL cfg_same_edge got %0d want 2", res);
    end
  endtask

  task automatic test_random();
    int res, lat, key, hold; bit irb, hb, to;
    int v [NB];
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NB; i++) v[i] = int'($urandom_range(0, 255));
      for (int i = 0; i < NB; i++)
        for (int j = 0; j < NB - 1 - i; j++)
          if (v[j] > v[j+1]) begin int t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
      for (int i = 0; i < NB; i++) write_cfg(i, v[i]);
      for (int k = 0; k < 10; k++) begin
        key  = (k % 3 == 0) ? v[$urandom_range(0, NB-1)] : int'($urandom_range(0, 255));
        hold = int'($urandom_range(0, 2));
        do_query(key, hold, 0, 0, 0, res, lat, irb, hb, to);
        vectors++;
        if (to || res !== ref_range(key) || lat !== 3 || hb || irb) begin
          miscompares++;
          $display("FAIL random_query key=%0d got range=%0d lat=%0d want range=%0d lat=3", key, res, lat, ref_range(key));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int res, lat, seen; bit irb, hb, to;
    int keys [3] = '{0, 255, 45};
    load_std_table();
    in_valid = 1'b1; in_key = 8'd45;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_range !== 4'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset got rdy=%b vld=%b rng=%0d busy=%b want 1 0 0 0", in_ready, out_valid, out_range, busy);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < NB; i++) mdl_tbl[i] = 0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL async_reset_no_result got %0d valid cycles want 0", seen);
    end
    for (int i = 0; i < 3; i++) begin
      do_query(keys[i], 0, 0, 0, 0, res, lat, irb, hb, to);
      vectors++;
      if (to || res !== 7) begin
        miscompares++;
        $display("FAIL async_reset_table key=%0d got %0d want 7", keys[i], res);
      end
    end
  endtask

  task automatic test_back_to_back();
    int expq [$];
    int n_acc = 0, n_res = 0, last = -1, k, e;
    load_std_table();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && n_res < 6; cyc++) begin
      if (out_valid === 1'b1) begin
        vectors++;
        e = (expq.size() > 0) ? expq.pop_front() : -1;
        if (out_range !== e[3:0] || e < 0) begin
          miscompares++;
          $display("FAIL b2b_result got %0d want %0d", out_range, e);
        end
        n_res++;
      end
      if (in_ready === 1'b1) begin
        if (n_acc < 6) begin
          k = int'($urandom_range(0, 255));
          in_key = k[7:0];
          expq.push_back(ref_range(k));
          if (last >= 0) begin
            vectors++;
            if (cyc - last !== 5) begin
              miscompares++;
              $display("FAIL b2b_spacing got %0d want 5", cyc - last);
            end
          end
          last = cyc;
          n_acc++;
        end else in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    vectors++;
    if (n_res !== 6) begin
      miscompares++;
      $display("FAIL b2b_count got %0d want 6", n_res);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_cfg_during_search();
    test_cfg_then_search();
    test_random();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
